home_cell_broadcaster: RTL

Sequencer that reads one home cell's particle memory and broadcasts it to the per-cell reference extractors and filters. It first emits the particle-count word, then, for every reference particle, streams the full particle list twice (phase 0, then phase 1, one sweep per half-shell cell group). It generates all control fields the extractors consume: `particle_id`, `ref_id`, `phase`, `prev_phase` and `reading_particle_num`. The block sits between the home cell particle memory and the extractor bank inside the MD core.

---
 rtl/home_cell_broadcaster_if.sv | 46 ++++
 rtl/home_cell_broadcaster.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/home_cell_broadcaster_if.sv
// Shared particle types and the bus bundle between the home cell memory,
// the broadcaster and the extractor bank.
package md_pkg;
  localparam int PARTICLE_ID_WIDTH = 8;
  localparam int OFFSET_WIDTH      = 16;

  typedef struct packed {
    logic [OFFSET_WIDTH-1:0] offset_x;
    logic [OFFSET_WIDTH-1:0] offset_y;
    logic [OFFSET_WIDTH-1:0] offset_z;
  } offset_tuple_t;
endpackage

interface home_cell_broadcaster_if #(
  parameter int W = md_pkg::PARTICLE_ID_WIDTH
);
  import md_pkg::*;

  logic          start;
  logic          stall;
  logic          rd_en;
  logic [W-1:0]  rd_addr;
  offset_tuple_t rd_data;
  offset_tuple_t raw_home_pos;
  logic          bcast_valid;
  logic          reading_particle_num;
  logic [W-1:0]  particle_id;
  logic [W-1:0]  ref_id;
  logic          phase;
  logic          prev_phase;
  logic [W-1:0]  particle_count;
  logic          busy;
  logic          done;

  modport master (
    input  start, stall, rd_data,
    output rd_en, rd_addr, raw_home_pos, bcast_valid, reading_particle_num,
           particle_id, ref_id, phase, prev_phase, particle_count, busy, done
  );

  modport slave (
    output start, stall, rd_data,
    input  rd_en, rd_addr, raw_home_pos, bcast_valid, reading_particle_num,
           particle_id, ref_id, phase, prev_phase, particle_count, busy, done
  );
endinterface

// File: rtl/home_cell_broadcaster.sv
// Reads a home cell's count word, then streams its particle list twice per
// reference particle, tagging every beat with the extractor control fields.
//
// state    | meaning
// IDLE     | waiting for start
// RD_NUM   | issue the read of the count word (address 0)
// WAIT_NUM | waiting for the count word to return
// SWEEP    | issue particle reads over (ref, phase, particle)
// DRAIN    | wait for in-flight beats, then pulse done
module home_cell_broadcaster #(
  parameter int RD_LATENCY        = 2,
  parameter int PARTICLE_ID_WIDTH = md_pkg::PARTICLE_ID_WIDTH
) (
  input logic                     clk,
  input logic                     rst,
  home_cell_broadcaster_if.master bus
);
  localparam int W = PARTICLE_ID_WIDTH;

  typedef enum logic [2:0] {IDLE, RD_NUM, WAIT_NUM, SWEEP, DRAIN} state_t;

  typedef struct packed {
    logic         valid;
    logic         num;
    logic [W-1:0] r;
    logic         p;
    logic [W-1:0] k;
  } tag_t;

  state_t                 state, state_nx;
  tag_t [RD_LATENCY-1:0]  pipe;
  tag_t                   head, tag_nx;
  logic [W-1:0]           cnt, r, k;
  logic                   p;
  logic                   rd_en, done, issue, last_issue, count_beat, pipe_busy;
  md_pkg::offset_tuple_t  raw_pos;
  logic                   bcast_valid, reading_num, phase, prev_phase;
  logic [W-1:0]           particle_id, ref_id;

  assign head       = pipe[RD_LATENCY-1];
  assign count_beat = head.valid & head.num;
  assign last_issue = (r == cnt) && p && (k == cnt);

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < RD_LATENCY; i++) pipe_busy = pipe_busy | pipe[i].valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    issue    = 1'b0;
    done     = 1'b0;
    tag_nx   = '0;
    case (state)
      IDLE: if (bus.start) state_nx = RD_NUM;
      RD_NUM: begin
        if (!bus.stall) begin
          rd_en        = 1'b1;
          tag_nx.valid = 1'b1;
          tag_nx.num   = 1'b1;
          tag_nx.r     = W'(1);
          state_nx     = WAIT_NUM;
        end
      end
      WAIT_NUM: begin
        if (count_beat)
          state_nx = (bus.rd_data.offset_x[W-1:0] == '0) ? DRAIN : SWEEP;
      end
      SWEEP: begin
        if (!bus.stall) begin
          rd_en        = 1'b1;
          issue        = 1'b1;
          tag_nx.valid = 1'b1;
          tag_nx.r     = r;
          tag_nx.p     = p;
          tag_nx.k     = k;
          if (last_issue) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        // wait for the final beat to be visible for one cycle before done
        if (!pipe_busy && !bcast_valid) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe        <= '0;
      cnt         <= '0;
      r           <= '0;
      p           <= 1'b0;
      k           <= '0;
      raw_pos     <= '0;
      bcast_valid <= 1'b0;
      reading_num <= 1'b0;
      ref_id      <= '0;
      phase       <= 1'b0;
      particle_id <= '0;
      prev_phase  <= 1'b0;
    end else begin
      pipe[0] <= tag_nx;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];

      if (state == WAIT_NUM && count_beat) begin
        cnt <= bus.rd_data.offset_x[W-1:0];
        r   <= W'(1);
        p   <= 1'b0;
        k   <= W'(1);
      end else if (issue && !last_issue) begin
        // counters stop at {N,1,N} so they never wrap even for N = 2^W-1
        if (k == cnt) begin
          k <= W'(1);
          p <= ~p;
          if (p) r <= r + W'(1);
        end else begin
          k <= k + W'(1);
        end
      end

      bcast_valid <= head.valid;
      reading_num <= count_beat;
      if (head.valid) begin
        raw_pos     <= bus.rd_data;
        ref_id      <= head.r;
        phase       <= head.p;
        particle_id <= head.k;
      end
      prev_phase <= phase;
    end
  end

  assign bus.rd_en                = rd_en;
  assign bus.rd_addr              = (state == SWEEP) ? k : '0;
  assign bus.raw_home_pos         = raw_pos;
  assign bus.bcast_valid          = bcast_valid;
  assign bus.reading_particle_num = reading_num;
  assign bus.particle_id          = particle_id;
  assign bus.ref_id               = ref_id;
  assign bus.phase                = phase;
  assign bus.prev_phase           = prev_phase;
  assign bus.particle_count       = cnt;
  assign bus.busy                 = (state != IDLE);
  assign bus.done                 = done;
endmodule
